rr_mux41_stream: RTL
====================

Name: rr_mux41_stream

Overview:
4-to-1 streaming merge block, the gathering counterpart of the team's 1-to-4 demultiplexer. It arbitrates four valid/ready input channels round-robin and forwards one beat per cycle through a registered output stage. Each beat is tagged with its 2-bit source index, so a downstream 1-to-4 demux can route responses back. A multi-beat packet (framed by `last`) holds the grant until its final beat.

Parameters:
- WIDTH, 8, data bits per channel beat.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 4, per-channel beat valid; bit i = channel i.
- in_data, input, 4*WIDTH, channel i data on bits [i*WIDTH +: WIDTH].
- in_last, input, 4, per-channel end-of-packet flag, qualified by in_valid[i].
- in_ready, output, 4, per-channel accept; at most one bit set per cycle.
- out_valid, output, 1, registered output beat valid.
- out_data, output, WIDTH, registered output data.
- out_last, output, 1, registered end-of-packet flag.
- out_sel, output, 2, registered source channel index of the current output beat.
- out_ready, input, 1, downstream accept.
- busy, output, 1, high while a packet is locked (state LOCKED).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, busy=0, rr pointer ptr=0, state=IDLE. in_ready=4'b0000 while rst is high.
- Transfers: an input beat transfers when in_valid[i] & in_ready[i]. An output beat transfers when out_valid & out_ready.
- load_en = ~out_valid | out_ready. The output register loads only when load_en=1.
- When load_en=1 and no input transfers: out_valid is cleared to 0 at the edge. out_data, out_last and out_sel hold their values.
- States: IDLE (no packet open) and LOCKED (packet open on channel lch).
- Arbitration in IDLE:
  - grant = first i with in_valid[i]=1, scanning ptr, ptr+1, … modulo 4 (wrap 3→0).
  - No valid channel → no grant.
- Arbitration in LOCKED:
  - grant = lch only. Other channels' in_ready stay 0 even if valid.
  - If in_valid[lch]=0, no transfer occurs. Other channels wait.
- in_ready[i] = load_en & (grant==i) & ~rst. This is combinational from in_valid, out_valid, out_ready and state; no combinational path from in_data.
- On an input transfer from channel g:
  - out_data ← in_data[g], out_last ← in_last[g], out_sel ← g, out_valid ← 1.
- State transitions on an input transfer from channel g:
  - in_last[g]=0 in IDLE → LOCKED, lch ← g.
  - in_last[g]=0 in LOCKED → stay in LOCKED.
  - in_last[g]=1 → IDLE, ptr ← (g+1) mod 4. This includes a single-beat packet arriving in IDLE.
- ptr changes only on the last-beat transfer.
- busy = (state==LOCKED).
- Latency: input transfer at edge N → out_valid=1 after edge N.
- Throughput: one beat per cycle while out_ready=1. There is no bubble between packets or between channels.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_last and out_sel hold stable and all in_ready=0.
- Simultaneous events: an output beat transfer and an input transfer in the same cycle are legal. The register is overwritten with the new beat and out_valid stays 1.
- Reset mid-packet: the packet is aborted. The block returns to IDLE with ptr=0, and any in-flight output beat is dropped.

Test Plan:
1. Reset with all in_valid=1 → in_ready=0000 during reset. After release with out_ready=1 and single-beat packets (in_last=1111), out_sel sequence is 0,1,2,3,0 on consecutive cycles with out_valid held 1.
2. WIDTH=8, only channel 2 valid, data 0xA5, last=1, out_ready=1 → in_ready=0100. Next cycle: out_valid=1, out_data=0xA5, out_sel=2, out_last=1, busy=0.
3. Channel 1 sends 3 beats (0x11, 0x12, 0x13, last on the third) while channels 0 and 3 are continuously valid → output is 0x11, 0x12, 0x13 all with out_sel=1 and busy=1 during the packet. The next grant goes to channel 3 (ptr=2 scans 2→3).
4. out_ready=0 for 5 cycles while out_valid=1 with out_data=0x3C → out_data/out_sel stay constant and in_ready=0000. When out_ready returns to 1, the next beat appears one cycle later with no beat lost or duplicated.
5. Locked on channel 0, in_valid[0] drops for 2 cycles while channel 1 is valid → in_ready[1] stays 0 and out_valid clears. When channel 0 resumes, the packet completes, then channel 1 is granted.
6. Assert rst mid-packet on channel 3 (busy=1, out_valid=1) → outputs clear immediately (async). After release, state is IDLE and the first grant follows ptr=0.

Source files
------------

// File: rtl/rr_mux41_stream.sv
// Four-channel valid/ready round-robin merge with packet locking and a registered
// output stage that tags each beat with its source channel index.
module rr_mux41_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       lch;
  logic             load_en;
  logic             gnt_valid;
  logic [1:0]       grant;
  logic [1:0]       scan;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  assign load_en = ~out_valid | out_ready;

  // While locked only the packet owner may win; otherwise scan from ptr with wrap.
  always_comb begin
    gnt_valid = 1'b0;
    grant     = lch;
    scan      = '0;
    if (state == LOCKED) begin
      gnt_valid = in_valid[lch];
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        scan = ptr + k[1:0];
        if (!gnt_valid && in_valid[scan]) begin
          gnt_valid = 1'b1;
          grant     = scan;
        end
      end
    end
  end

  always_comb begin
    beat_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant == i[1:0]) beat_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign beat_last = in_last[grant];
  assign xfer      = load_en & gnt_valid & ~rst;
  assign in_ready  = xfer ? (4'b0001 << grant) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lch       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_last  <= beat_last;
        out_sel   <= grant;
        if (beat_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= grant + 2'd1;
        end else begin
          state <= LOCKED;
          busy  <= 1'b1;
          lch   <= grant;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
